dffx_sync_chk: RTL

Receiving-end checker for X-tagged flop outputs. It samples the data, metastability and toggle tags produced by an instrumented capture flop and models a parameterised synchronizer chain carrying those tags. It reports tag captures and output-reaching tags through a single-entry valid/ack event port, with a saturating capture counter. It sits downstream of every instrumented clock-domain-crossing flop in the analysis netlist, one instance per crossing.

---
 rtl/dffx_sync_chk.sv | 99 +++++++++
 1 files changed

// File: rtl/dffx_sync_chk.sv
// Receiving-end checker for X-tagged capture flops: tag synchronizer chain plus single-entry event port.
// Define XSYNC_PESSIMISTIC_EN to carry metastability tags through every stage instead of resolving them in stage 0.
module dffx_sync_chk #(
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             CK,
    input  logic             RS,
    input  logic             E,
    input  logic             D,
    input  logic             M,
    input  logic             T,
    output logic             Q,
    output logic             QX,
    output logic             EV,
    input  logic             EA,
    output logic [1:0]       EC,
    output logic [CNT_W-1:0] CNT,
    output logic             OVF,
    output logic             VIO
);

    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [1:0] EC_CAPTURE = 2'b01;
    localparam logic [1:0] EC_VIOL    = 2'b10;

    logic [STAGES-1:0] d_q, m_q, t_q;
    state_t            state, state_nxt;
    logic [1:0]        ec_q;
    logic              cap, viol, hit, load;
    logic [1:0]        code;

    always_ff @(posedge CK or posedge RS) begin
        if (RS) begin
            d_q <= '0;
            m_q <= '0;
            t_q <= '0;
        end else if (E) begin
            d_q <= {d_q[STAGES-2:0], D};
            t_q <= {t_q[STAGES-2:0], T};
`ifdef XSYNC_PESSIMISTIC_EN
            m_q <= {m_q[STAGES-2:0], M};
`else
            // Metastability is assumed resolved after the first stage.
            m_q <= {{(STAGES-1){1'b0}}, M};
`endif
        end
    end

    assign Q  = d_q[STAGES-1];
    assign QX = m_q[STAGES-1] | t_q[STAGES-1];

    assign cap  = E & (M | T);
    assign viol = E & QX;
    assign hit  = cap | viol;
    // A violation outranks a simultaneous capture; only one event is generated.
    assign code = viol ? EC_VIOL : EC_CAPTURE;

    always_ff @(posedge CK or posedge RS) begin
        if (RS) state <= IDLE;
        else    state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hit) state_nxt = PEND;
            PEND:    if (EA && !hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        EV = (state == PEND);
        EC = EV ? ec_q : 2'b00;
    end

    assign load = hit && (state == IDLE || EA);

    always_ff @(posedge CK or posedge RS) begin
        if (RS) begin
            ec_q <= 2'b00;
            CNT  <= '0;
            OVF  <= 1'b0;
            VIO  <= 1'b0;
        end else begin
            if (load)
                ec_q <= code;
            if (hit && state == PEND && !EA)
                OVF <= 1'b1;
            if (viol)
                VIO <= 1'b1;
            if (cap && CNT != {CNT_W{1'b1}})
                CNT <= CNT + CNT_W'(1);
        end
    end

endmodule
